// File: rtl/blink_period_meter.sv
// Measures the half-period of a slow asynchronous toggling input in clk cycles.
// Path: synchroniser -> glitch filter -> edge-to-edge timer -> valid/ready result with sticky flags.
module blink_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 100_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic             period_ready,
  input  logic             clr_flags,
  output logic             sig_level,
  output logic [CNT_W-1:0] period_data,
  output logic             period_valid,
  output logic             timeout,
  output logic             overrun
);

  localparam int               FW        = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MEAS = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_out;
  logic [FW-1:0]          r_filt_cnt;
  logic                   r_level;
  logic                   r_edge;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_res_vld;
  logic [CNT_W-1:0]       w_res;
  logic                   w_to_set;

  logic [CNT_W-1:0]       r_data;
  logic                   r_valid;
  logic                   r_timeout;
  logic                   r_overrun;
  logic                   w_accept;
  logic                   w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // A level change is accepted only after FILTER consecutive differing samples;
  // r_edge pulses in the same cycle sig_level takes the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
      r_level    <= 1'b0;
      r_edge     <= 1'b0;
    end else begin
      r_edge <= 1'b0;
      if (w_sync_out == r_level) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_filt_cnt <= '0;
        r_level    <= w_sync_out;
        r_edge     <= 1'b1;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // cnt holds (cycles since last edge - 1), so the edge-cycle result is cnt+1.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_res_vld    = 1'b0;
    w_res        = r_cnt + 1'b1;
    w_to_set     = 1'b0;
    if (!en) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_edge) begin
            w_state_next = S_MEAS;
            w_cnt_next   = '0;
          end
        end
        S_MEAS: begin
          if (r_edge) begin
            w_res_vld  = 1'b1;
            w_cnt_next = '0;
          end else if (r_cnt == TO_LAST) begin
            w_to_set     = 1'b1;
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign w_accept = r_valid & period_ready;
  // A result arriving while an unaccepted one is held (and not taken this cycle) is lost.
  assign w_drop   = w_res_vld & r_valid & ~period_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_res_vld && !w_drop) begin
        r_data  <= w_res;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_to_set) begin
        r_timeout <= 1'b1;
      end else if (clr_flags) begin
        r_timeout <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_flags) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign sig_level    = r_level;
  assign period_data  = r_data;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter: steady toggle, glitches, timeout,
// backpressure, accept-with-new-result and mid-measurement aborts.
module tb_blink_period_meter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             sig_in;
  logic             period_ready;
  logic             clr_flags;
  logic             sig_level;
  logic [CNT_W-1:0] period_data;
  logic             period_valid;
  logic             timeout;
  logic             overrun;

  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               n_acc = 0;
  logic [CNT_W-1:0] last_acc = '0;

  blink_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (1000),
    .SYNC_STAGES(2),
    .FILTER     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sig_in      (sig_in),
    .period_ready(period_ready),
    .clr_flags   (clr_flags),
    .sig_level   (sig_level),
    .period_data (period_data),
    .period_valid(period_valid),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One line per accepted result.
  always @(posedge clk) begin
    if (rst_n && period_valid && period_ready) begin
      n_acc    <= n_acc + 1;
      last_acc <= period_data;
      $display("accept: period_data=%0d at cycle %0d", period_data, cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    en           = 1'b0;
    sig_in       = 1'b0;
    period_ready = 1'b0;
    clr_flags    = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    en           = 1'b1;
    sig_in       = 1'b1;
    period_ready = 1'b1;
    clr_flags    = 1'b0;
    step(3);
    n_checks++;
    if ({sig_level, period_data, period_valid, timeout, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lvl=%b data=%0d vld=%b to=%b ov=%b want all 0",
               sig_level, period_data, period_valid, timeout, overrun);
    end
  endtask

  task automatic test_steady();
    int t0;
    int tt;
    apply_reset();
    en = 1'b1;
    period_ready = 1'b1;
    t0 = cyc;
    sig_in = 1'b1;
    wait_until(t0 + 6);
    n_checks++;
    if (sig_level !== 1'b1) begin n_fail++; $display("FAIL steady_level_latency: got %b want 1", sig_level); end
    wait_until(t0 + 7);
    n_checks++;
    if (period_valid !== 1'b0) begin n_fail++; $display("FAIL steady_first_edge_arms: got valid=%b want 0", period_valid); end
    for (int k = 1; k <= 3; k++) begin
      tt = t0 + 100 * k;
      wait_until(tt);
      sig_in = ~sig_in;
      wait_until(tt + 6);
      n_checks++;
      if (period_valid !== 1'b0) begin n_fail++; $display("FAIL steady_early_valid[%0d]: got %b want 0", k, period_valid); end
      wait_until(tt + 7);
      n_checks++;
      if (period_valid !== 1'b1 || period_data !== 16'd100) begin
        n_fail++;
        $display("FAIL steady_result[%0d]: got valid=%b data=%0d want valid=1 data=100", k, period_valid, period_data);
      end
      wait_until(tt + 8);
      n_checks++;
      if (period_valid !== 1'b0) begin n_fail++; $display("FAIL steady_pulse_len[%0d]: got %b want 0", k, period_valid); end
    end
  endtask

  task automatic test_glitch();
    int t0;
    int t1;
    int base;
    apply_reset();
    en = 1'b1;
    period_ready = 1'b1;
    t0 = cyc;
    sig_in = 1'b1;
    wait_until(t0 + 50);
    base = n_acc;
    sig_in = 1'b0;
    wait_until(t0 + 53);
    sig_in = 1'b1;
    for (int c = t0 + 54; c <= t0 + 64; c++) begin
      wait_until(c);
      n_checks++;
      if (sig_level !== 1'b1) begin n_fail++; $display("FAIL glitch3_level at cycle %0d: got %b want 1", c, sig_level); end
    end
    wait_until(t0 + 100);
    sig_in = 1'b0;
    wait_until(t0 + 107);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd100) begin
      n_fail++;
      $display("FAIL glitch3_result: got valid=%b data=%0d want valid=1 data=100", period_valid, period_data);
    end
    wait_until(t0 + 108);
    n_checks++;
    if (n_acc - base !== 1) begin n_fail++; $display("FAIL glitch3_result_count: got %0d want 1", n_acc - base); end
    t1 = t0 + 100;
    wait_until(t1 + 40);
    sig_in = 1'b1;
    wait_until(t1 + 44);
    sig_in = 1'b0;
    wait_until(t1 + 46);
    n_checks++;
    if (sig_level !== 1'b1) begin n_fail++; $display("FAIL glitch4_rise_level: got %b want 1", sig_level); end
    wait_until(t1 + 47);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd40) begin
      n_fail++;
      $display("FAIL glitch4_first: got valid=%b data=%0d want valid=1 data=40", period_valid, period_data);
    end
    wait_until(t1 + 50);
    n_checks++;
    if (sig_level !== 1'b0) begin n_fail++; $display("FAIL glitch4_fall_level: got %b want 0", sig_level); end
    wait_until(t1 + 51);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd4) begin
      n_fail++;
      $display("FAIL glitch4_second: got valid=%b data=%0d want valid=1 data=4", period_valid, period_data);
    end
    wait_until(t1 + 100);
    sig_in = 1'b1;
    wait_until(t1 + 107);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd56) begin
      n_fail++;
      $display("FAIL glitch4_remaining: got valid=%b data=%0d want valid=1 data=56", period_valid, period_data);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int e;
    int r0;
    apply_reset();
    en = 1'b1;
    period_ready = 1'b1;
    t0 = cyc;
    sig_in = 1'b1;
    e = t0 + 6;
    wait_until(e);
    n_checks++;
    if (sig_level !== 1'b1) begin n_fail++; $display("FAIL timeout_arm_level: got %b want 1", sig_level); end
    // The timeout decision falls in the 1000th cycle after the edge and is registered.
    wait_until(e + 1000);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", timeout); end
    wait_until(e + 1001);
    n_checks++;
    if (timeout !== 1'b1 || period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_set: got to=%b valid=%b want to=1 valid=0", timeout, period_valid);
    end
    r0 = cyc + 10;
    wait_until(r0);
    sig_in = 1'b0;
    wait_until(r0 + 7);
    n_checks++;
    if (period_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_resume_arm: got valid=%b want 0", period_valid); end
    wait_until(r0 + 100);
    sig_in = 1'b1;
    wait_until(r0 + 107);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd100 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_resume_result: got valid=%b data=%0d to=%b want valid=1 data=100 to=1",
               period_valid, period_data, timeout);
    end
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", timeout); end
  endtask

  task automatic test_backpressure();
    int t0;
    apply_reset();
    en = 1'b1;
    period_ready = 1'b0;
    t0 = cyc;
    sig_in = 1'b1;
    wait_until(t0 + 100);
    sig_in = 1'b0;
    wait_until(t0 + 107);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd100) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%b data=%0d want valid=1 data=100", period_valid, period_data);
    end
    wait_until(t0 + 250);
    sig_in = 1'b1;
    wait_until(t0 + 256);
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_early: got %b want 0", overrun); end
    wait_until(t0 + 257);
    n_checks++;
    if (overrun !== 1'b1 || period_data !== 16'd100 || period_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_dropped: got ov=%b data=%0d valid=%b want ov=1 data=100 valid=1",
               overrun, period_data, period_valid);
    end
    wait_until(t0 + 260);
    period_ready = 1'b1;
    step(1);
    n_checks++;
    if (period_valid !== 1'b0 || last_acc !== 16'd100) begin
      n_fail++;
      $display("FAIL bp_accept: got valid=%b accepted=%0d want valid=0 accepted=100", period_valid, last_acc);
    end
  endtask

  task automatic test_accept_new();
    int t0;
    apply_reset();
    en = 1'b1;
    period_ready = 1'b0;
    t0 = cyc;
    sig_in = 1'b1;
    wait_until(t0 + 100);
    sig_in = 1'b0;
    wait_until(t0 + 107);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd100) begin
      n_fail++;
      $display("FAIL acc_new_held: got valid=%b data=%0d want valid=1 data=100", period_valid, period_data);
    end
    wait_until(t0 + 230);
    sig_in = 1'b1;
    wait_until(t0 + 236);
    period_ready = 1'b1;
    wait_until(t0 + 237);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd130 || overrun !== 1'b0 || last_acc !== 16'd100) begin
      n_fail++;
      $display("FAIL acc_new_same_cycle: got valid=%b data=%0d ov=%b accepted=%0d want valid=1 data=130 ov=0 accepted=100",
               period_valid, period_data, overrun, last_acc);
    end
    wait_until(t0 + 238);
    n_checks++;
    if (period_valid !== 1'b0 || last_acc !== 16'd130) begin
      n_fail++;
      $display("FAIL acc_new_drain: got valid=%b accepted=%0d want valid=0 accepted=130", period_valid, last_acc);
    end
  endtask

  task automatic test_abort();
    int t0;
    int r;
    int x;
    int t1;
    apply_reset();
    en = 1'b1;
    period_ready = 1'b0;
    t0 = cyc;
    sig_in = 1'b1;
    wait_until(t0 + 100);
    sig_in = 1'b0;
    wait_until(t0 + 200);
    sig_in = 1'b1;
    wait_until(t0 + 250);
    n_checks++;
    if (sig_level !== 1'b1 || period_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_state: got lvl=%b valid=%b ov=%b want 1 1 1", sig_level, period_valid, overrun);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sig_level, period_data, period_valid, timeout, overrun} !== '0) begin
      n_fail++;
      $display("FAIL abort_async_reset: got lvl=%b data=%0d vld=%b to=%b ov=%b want all 0",
               sig_level, period_data, period_valid, timeout, overrun);
    end
    step(1);
    rst_n = 1'b1;
    period_ready = 1'b1;
    r = cyc;
    wait_until(r + 6);
    n_checks++;
    if (sig_level !== 1'b1) begin n_fail++; $display("FAIL abort_relevel: got %b want 1", sig_level); end
    wait_until(r + 7);
    n_checks++;
    if (period_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rst_arm_only: got valid=%b want 0", period_valid); end
    x = r + 50;
    wait_until(x);
    sig_in = 1'b0;
    wait_until(x + 7);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd50) begin
      n_fail++;
      $display("FAIL abort_rst_result: got valid=%b data=%0d want valid=1 data=50", period_valid, period_data);
    end
    t1 = x + 20;
    wait_until(t1);
    en = 1'b0;
    wait_until(t1 + 50);
    sig_in = 1'b1;
    wait_until(t1 + 56);
    n_checks++;
    if (sig_level !== 1'b1) begin n_fail++; $display("FAIL abort_en_filter_tracks: got %b want 1", sig_level); end
    wait_until(t1 + 57);
    n_checks++;
    if (period_valid !== 1'b0) begin n_fail++; $display("FAIL abort_en_no_result: got valid=%b want 0", period_valid); end
    wait_until(t1 + 70);
    en = 1'b1;
    wait_until(t1 + 150);
    sig_in = 1'b0;
    wait_until(t1 + 157);
    n_checks++;
    if (period_valid !== 1'b0) begin n_fail++; $display("FAIL abort_en_arm_only: got valid=%b want 0", period_valid); end
    wait_until(t1 + 220);
    sig_in = 1'b1;
    wait_until(t1 + 227);
    n_checks++;
    if (period_valid !== 1'b1 || period_data !== 16'd70) begin
      n_fail++;
      $display("FAIL abort_en_result: got valid=%b data=%0d want valid=1 data=70", period_valid, period_data);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_glitch();
    test_timeout();
    test_backpressure();
    test_accept_new();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
